// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter that shares one data-memory port among the per-thread LSUs.
// Every output is registered; a granted request runs to completion before the next grant.
module lsu_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready,
  output logic                                 busy
);

  // state      | meaning
  // IDLE       | scanning LSUs from rr_ptr for the next request
  // READ_WAIT  | read presented to memory, waiting for mem_read_ready
  // WRITE_WAIT | write presented to memory, waiting for mem_write_ready
  // RELAY      | ready shown to the granted LSU until it drops its valid
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

  localparam int PTR_BITS = $clog2(NUM_CONSUMERS);

  state_t                             state, state_next;
  logic [PTR_BITS-1:0]                rr_ptr, rr_ptr_next;
  logic [PTR_BITS-1:0]                grant_id, grant_id_next;
  logic                               op_write, op_write_next;
  logic                               mem_read_valid_next, mem_write_valid_next;
  logic [ADDR_BITS-1:0]               mem_read_address_next, mem_write_address_next;
  logic [DATA_BITS-1:0]               mem_write_data_next;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_next, consumer_write_ready_next;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_next;
  logic                               busy_next;

  logic                               pick_valid;
  logic [PTR_BITS-1:0]                pick_id;
  logic                               pick_write;

  function automatic logic [PTR_BITS-1:0] wrap_idx(input int base, input int offs);
    int sum;
    sum = base + offs;
    if (sum >= NUM_CONSUMERS) sum = sum - NUM_CONSUMERS;
    return PTR_BITS'(sum);
  endfunction

  // First requester at or after rr_ptr; a pending read beats a write on the same LSU.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = rr_ptr;
    pick_write = 1'b0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (!pick_valid &&
          (consumer_read_valid[wrap_idx(int'(rr_ptr), i)] ||
           consumer_write_valid[wrap_idx(int'(rr_ptr), i)])) begin
        pick_valid = 1'b1;
        pick_id    = wrap_idx(int'(rr_ptr), i);
        pick_write = !consumer_read_valid[wrap_idx(int'(rr_ptr), i)];
      end
    end
  end

  always_comb begin
    state_next                = state;
    rr_ptr_next               = rr_ptr;
    grant_id_next             = grant_id;
    op_write_next             = op_write;
    mem_read_valid_next       = mem_read_valid;
    mem_read_address_next     = mem_read_address;
    mem_write_valid_next      = mem_write_valid;
    mem_write_address_next    = mem_write_address;
    mem_write_data_next       = mem_write_data;
    consumer_read_ready_next  = consumer_read_ready;
    consumer_write_ready_next = consumer_write_ready;
    consumer_read_data_next   = consumer_read_data;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_id_next = pick_id;
          op_write_next = pick_write;
          if (pick_write) begin
            mem_write_valid_next   = 1'b1;
            mem_write_address_next = consumer_write_address[pick_id*ADDR_BITS +: ADDR_BITS];
            mem_write_data_next    = consumer_write_data[pick_id*DATA_BITS +: DATA_BITS];
            state_next             = WRITE_WAIT;
          end else begin
            mem_read_valid_next   = 1'b1;
            mem_read_address_next = consumer_read_address[pick_id*ADDR_BITS +: ADDR_BITS];
            state_next            = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_next                                     = 1'b0;
          consumer_read_ready_next[grant_id]                      = 1'b1;
          consumer_read_data_next[grant_id*DATA_BITS +: DATA_BITS] = mem_read_data;
          state_next                                              = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_next                = 1'b0;
          consumer_write_ready_next[grant_id] = 1'b1;
          state_next                          = RELAY;
        end
      end
      RELAY: begin
        if (op_write ? !consumer_write_valid[grant_id] : !consumer_read_valid[grant_id]) begin
          consumer_read_ready_next  = '0;
          consumer_write_ready_next = '0;
          rr_ptr_next               = wrap_idx(int'(grant_id), 1);
          state_next                = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant_id             <= '0;
      op_write             <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_next;
      rr_ptr               <= rr_ptr_next;
      grant_id             <= grant_id_next;
      op_write             <= op_write_next;
      mem_read_valid       <= mem_read_valid_next;
      mem_read_address     <= mem_read_address_next;
      mem_write_valid      <= mem_write_valid_next;
      mem_write_address    <= mem_write_address_next;
      mem_write_data       <= mem_write_data_next;
      consumer_read_ready  <= consumer_read_ready_next;
      consumer_write_ready <= consumer_write_ready_next;
      consumer_read_data   <= consumer_read_data_next;
      busy                 <= busy_next;
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: behavioural memory and LSU models around the DUT,
// with expected memory operations and LSU responses queued in grant order.
module tb_lsu_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    consumer_read_valid;
  logic [N*AW-1:0] consumer_read_address;
  logic [N-1:0]    consumer_read_ready;
  logic [N*DW-1:0] consumer_read_data;
  logic [N-1:0]    consumer_write_valid;
  logic [N*AW-1:0] consumer_write_address;
  logic [N*DW-1:0] consumer_write_data;
  logic [N-1:0]    consumer_write_ready;
  logic            mem_read_valid;
  logic [AW-1:0]   mem_read_address;
  logic            mem_read_ready;
  logic [DW-1:0]   mem_read_data;
  logic            mem_write_valid;
  logic [AW-1:0]   mem_write_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_write_ready;
  logic            busy;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready),
    .busy                   (busy)
  );

  typedef struct {bit wr; logic [7:0] addr; logic [7:0] data;} mem_exp_t;
  typedef struct {int id; bit wr; logic [7:0] data;} rsp_exp_t;
  typedef struct {int id; bit wr; logic [7:0] addr; logic [7:0] data; int wt; int hold; bit spur;} vec_t;

  mem_exp_t   mem_q[$];
  rsp_exp_t   rsp_q[$];
  logic [7:0] mem_model [256];
  logic [7:0] gold_mem  [256];
  vec_t       vecs [5];

  int         n_cmp = 0;
  int         n_bad = 0;
  int         mem_wait, rcnt, wcnt, busy_cycles, memv_cycles;
  logic [7:0] r_lat_a, w_lat_a, w_lat_d;
  bit         spur_r, spur_w;
  int         hold [N];
  bit         rearm [N];
  bit         rearm_pend [N];
  bit         seen_r [N];
  bit         seen_w [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {mem_read_valid, mem_read_address, mem_write_valid, mem_write_address,
                 mem_write_data, busy, consumer_read_ready, consumer_write_ready}, 64'd0);
    check({name, "_rdata"}, consumer_read_data, 64'd0);
  endtask

  // One clock: invariants, memory responder, then LSU behaviour and response scoreboard.
  task automatic tick();
    mem_exp_t me;
    rsp_exp_t re;
    @(negedge clk);
    check("mem_valid_excl", mem_read_valid & mem_write_valid, 0);
    check("ready_onehot", $countones({consumer_read_ready, consumer_write_ready}) <= 1, 1);
    if (busy) busy_cycles++;
    if (mem_read_valid || mem_write_valid) memv_cycles++;

    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    if (mem_read_valid) begin
      if (rcnt == 0) r_lat_a = mem_read_address;
      else check("rd_addr_stable", mem_read_address, r_lat_a);
      if (rcnt == mem_wait) begin
        mem_read_ready = 1'b1;
        mem_read_data  = mem_model[mem_read_address];
        if (mem_q.size() == 0) check("mem_q_underflow", 1, 0);
        else begin
          me = mem_q.pop_front();
          check("mem_op_is_write", 0, me.wr);
          check("mem_rd_addr", mem_read_address, me.addr);
        end
      end
      rcnt++;
    end else rcnt = 0;
    if (mem_write_valid) begin
      if (wcnt == 0) begin
        w_lat_a = mem_write_address;
        w_lat_d = mem_write_data;
      end else begin
        check("wr_addr_stable", mem_write_address, w_lat_a);
        check("wr_data_stable", mem_write_data, w_lat_d);
      end
      if (wcnt == mem_wait) begin
        mem_write_ready = 1'b1;
        mem_model[mem_write_address] = mem_write_data;
        if (mem_q.size() == 0) check("mem_q_underflow", 1, 0);
        else begin
          me = mem_q.pop_front();
          check("mem_op_is_write", 1, me.wr);
          check("mem_wr_addr", mem_write_address, me.addr);
          check("mem_wr_data", mem_write_data, me.data);
        end
      end
      wcnt++;
    end else wcnt = 0;
    if (spur_r && !mem_read_valid)  mem_read_ready  = 1'b1;
    if (spur_w && !mem_write_valid) mem_write_ready = 1'b1;

    for (int i = 0; i < N; i++) begin
      if (rearm_pend[i]) begin
        consumer_read_valid[i] = 1'b1;
        rearm_pend[i] = 1'b0;
      end
      if (consumer_read_valid[i] && consumer_read_ready[i]) begin
        if (!seen_r[i]) begin
          seen_r[i] = 1'b1;
          if (rsp_q.size() == 0) check("rsp_q_underflow", 1, 0);
          else begin
            re = rsp_q.pop_front();
            check("rsp_grant_id", i, re.id);
            check("rsp_is_write", 0, re.wr);
            check("rsp_rd_data", consumer_read_data[i*DW +: DW], re.data);
          end
        end
        if (hold[i] > 0) hold[i]--;
        else begin
          consumer_read_valid[i] = 1'b0;
          seen_r[i] = 1'b0;
          if (rearm[i]) begin
            rearm[i] = 1'b0;
            rearm_pend[i] = 1'b1;
          end
        end
      end
      if (consumer_write_valid[i] && consumer_write_ready[i]) begin
        if (!seen_w[i]) begin
          seen_w[i] = 1'b1;
          if (rsp_q.size() == 0) check("rsp_q_underflow", 1, 0);
          else begin
            re = rsp_q.pop_front();
            check("rsp_grant_id", i, re.id);
            check("rsp_is_write", 1, re.wr);
          end
        end
        if (hold[i] > 0) hold[i]--;
        else begin
          consumer_write_valid[i] = 1'b0;
          seen_w[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic issue(input int id, input bit wr, input logic [7:0] addr, input logic [7:0] data);
    if (wr) begin
      consumer_write_address[id*AW +: AW] = addr;
      consumer_write_data[id*DW +: DW]    = data;
      consumer_write_valid[id]            = 1'b1;
    end else begin
      consumer_read_address[id*AW +: AW] = addr;
      consumer_read_valid[id]            = 1'b1;
    end
  endtask

  task automatic expect_op(input int id, input bit wr, input logic [7:0] addr, input logic [7:0] data);
    mem_exp_t me;
    rsp_exp_t re;
    me.wr = wr; me.addr = addr; me.data = data;
    re.id = id; re.wr = wr; re.data = wr ? 8'd0 : gold_mem[addr];
    mem_q.push_back(me);
    rsp_q.push_back(re);
    if (wr) gold_mem[addr] = data;
  endtask

  task automatic req(input int id, input bit wr, input logic [7:0] addr, input logic [7:0] data);
    issue(id, wr, addr, data);
    expect_op(id, wr, addr, data);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      tick();
      k++;
      done = (consumer_read_valid == '0) && (consumer_write_valid == '0) && !busy &&
             (rsp_q.size() == 0) && (mem_q.size() == 0);
    end
    check({name, "_completes"}, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // read, wait, hold and spurious-other-op-ready patterns
    vecs[0] = '{1, 1'b0, 8'd8,  8'h00, 2, 0, 1'b0};
    vecs[1] = '{3, 1'b1, 8'd23, 8'd14, 0, 0, 1'b0};
    vecs[2] = '{0, 1'b0, 8'd23, 8'h00, 1, 2, 1'b1};
    vecs[3] = '{2, 1'b1, 8'd16, 8'hA5, 3, 0, 1'b1};
    vecs[4] = '{1, 1'b0, 8'd16, 8'h00, 0, 0, 1'b0};

    for (int a = 0; a < 256; a++) begin
      mem_model[a] = 8'(a % 8);
      gold_mem[a]  = 8'(a % 8);
    end
    for (int i = 0; i < N; i++) begin
      hold[i] = 0; rearm[i] = 0; rearm_pend[i] = 0; seen_r[i] = 0; seen_w[i] = 0;
    end
    reset_n = 1'b0;
    consumer_read_valid = '0; consumer_read_address = '0;
    consumer_write_valid = '0; consumer_write_address = '0; consumer_write_data = '0;
    mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
    spur_r = 0; spur_w = 0; mem_wait = 0; rcnt = 0; wcnt = 0;
    busy_cycles = 0; memv_cycles = 0;

    tick(); tick();
    check_zero("reset_state");
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      mem_wait = vecs[v].wt;
      hold[vecs[v].id] = vecs[v].hold;
      if (vecs[v].wr) spur_r = vecs[v].spur;
      else            spur_w = vecs[v].spur;
      busy_cycles = 0;
      memv_cycles = 0;
      req(vecs[v].id, vecs[v].wr, vecs[v].addr, vecs[v].data);
      wait_idle("vec", 60);
      spur_r = 0;
      spur_w = 0;
      check("vec_busy_cycles", busy_cycles, 2 + vecs[v].wt + vecs[v].hold);
      check("vec_mem_valid_cycles", memv_cycles, 1 + vecs[v].wt);
    end
    check("vec_rdata_slices", consumer_read_data, 32'h0000A50E);
    check("vec_write_landed", mem_model[23], 8'd14);

    spur_r = 1; spur_w = 1;
    tick(); tick(); tick();
    spur_r = 0; spur_w = 0;
    tick(); tick();
    check("idle_spurious_ready", {busy, mem_read_valid, mem_write_valid,
                                  consumer_read_ready, consumer_write_ready}, 0);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    mem_wait = 0;
    for (int i = 0; i < N; i++) req(i, 1'b0, 8'(i), 8'h00);
    wait_idle("contention", 80);
    check("contention_slices", consumer_read_data, 32'h03020100);

    req(0, 1'b0, 8'd4, 8'h00);
    req(2, 1'b0, 8'd5, 8'h00);
    rearm[0] = 1'b1;
    expect_op(0, 1'b0, 8'd4, 8'h00);
    wait_idle("fairness", 80);
    check("fairness_slices", consumer_read_data, 32'h03050104);

    mem_wait = 5;
    memv_cycles = 0;
    req(2, 1'b0, 8'd2, 8'h00);
    req(2, 1'b1, 8'd20, 8'h3C);
    wait_idle("read_then_write", 100);
    check("rw_mem_valid_cycles", memv_cycles, 12);
    check("rw_write_landed", mem_model[20], 8'h3C);
    check("rw_rdata_slice", consumer_read_data[2*DW +: DW], 8'd2);

    mem_wait = 20;
    issue(3, 1'b1, 8'd9, 8'h77);
    for (int k = 0; k < 10 && !mem_write_valid; k++) tick();
    check("rst_reached_write_wait", mem_write_valid, 1);
    tick(); tick();
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    consumer_write_valid = '0;
    tick(); tick();
    check_zero("held_reset");
    reset_n = 1'b1;
    tick(); tick(); tick();
    check_zero("post_reset_no_stale_ready");
    mem_wait = 0;
    req(1, 1'b0, 8'd1, 8'h00);
    req(3, 1'b0, 8'd3, 8'h00);
    wait_idle("post_reset_rr", 60);
    check("dropped_write", mem_model[9], 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Single-channel data-memory arbiter for a compute core. Shares one global data-memory port among NUM_CONSUMERS load/store units (one per thread).
- Picks one pending LDR/STR request round-robin and drives it to memory with a valid/ready handshake. Returns read data and completion to the granted LSU.
- Sits between the per-thread LSUs and the 8-bit-wide data memory used by kernels such as matrix add (A at 0..7, B at 8..15, C at 16..23).

Parameters:
ADDR_BITS, 8, data-memory address width
DATA_BITS, 8, data-memory word width
NUM_CONSUMERS, 4, number of LSU requesters (>=2)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request, held until its read_ready is seen
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed read addresses, LSU i at bits [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  out  NUM_CONSUMERS  per-LSU read complete
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed returned read data
consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed write addresses
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed write data
consumer_write_ready  out  NUM_CONSUMERS  per-LSU write complete
mem_read_valid  out  1  read request to memory
mem_read_address  out  ADDR_BITS  read address
mem_read_ready  in  1  memory read done; mem_read_data valid this cycle
mem_read_data  in  DATA_BITS  read data from memory
mem_write_valid  out  1  write request to memory
mem_write_address  out  ADDR_BITS  write address
mem_write_data  out  DATA_BITS  write data
mem_write_ready  in  1  memory write done
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0):
  - All outputs go to 0; consumer_read_data is all zeros.
  - State goes to IDLE, rr_ptr=0, grant_id=0.
  - Reset mid-transaction drops the outstanding request. No ready is issued for it.
- All outputs are registered.
- States: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE:
  - Scan consumers in order rr_ptr, rr_ptr+1, ... modulo NUM_CONSUMERS. The first index with read_valid or write_valid is granted.
  - If that LSU asserts both read_valid and write_valid, the read wins.
  - On grant: latch grant_id and the operation.
    - Read: set mem_read_valid=1 and mem_read_address = that LSU's address, then go to READ_WAIT.
    - Write: set mem_write_valid, address and data, then go to WRITE_WAIT.
  - With no request, stay in IDLE.
- READ_WAIT:
  - mem_read_valid and mem_read_address are held stable until mem_read_ready=1.
  - On that edge: mem_read_valid<=0, consumer_read_ready[grant_id]<=1, consumer_read_data slice[grant_id]<=mem_read_data, then go to RELAY.
- WRITE_WAIT:
  - Same as READ_WAIT, using mem_write_ready and consumer_write_ready.
  - mem_write_address and mem_write_data are held stable.
- RELAY:
  - Wait until the granted LSU deasserts the valid of the granted operation.
  - Then clear its ready, set rr_ptr <= (grant_id+1) mod NUM_CONSUMERS, and go to IDLE.
  - Ready is held high for every cycle that valid stays high.
- Latency:
  - Request seen in IDLE at edge N gives mem_*_valid=1 after edge N.
  - mem_*_ready seen at edge M gives consumer ready=1 after edge M.
  - With zero-wait memory and immediate LSU drop, a transaction takes 4 cycles.
- Data and address outputs:
  - consumer_read_data slices keep their last value until overwritten. Only the granted slice changes.
  - mem_*_address and mem_write_data may retain stale values when the matching valid is 0.
- Boundary cases:
  - mem_*_ready arriving while in IDLE or RELAY, or for the non-active operation, is ignored.
  - Never more than one of mem_read_valid and mem_write_valid is high.
  - Never more than one consumer ready bit is high.
  - A consumer with both read and write pending gets its read served first. Its write is served on its next round-robin turn.
  - rr_ptr wraps from NUM_CONSUMERS-1 to 0.
- Fairness: each pending requester is granted within NUM_CONSUMERS grants.

Test Plan:
- Single read: LSU1 reads addr 8, memory returns 8'd0 after 2 cycles -> mem_read_address=8 held for the whole wait; consumer_read_ready[1]=1 with data 0 until LSU1 drops valid; busy returns to 0.
- Single write: LSU3 writes 8'd14 to addr 23 with zero-wait memory -> mem_write_valid=1, address 23, data 14 for exactly one cycle; consumer_write_ready[3]=1; 4-cycle total.
- Contention: LSUs 0-3 all request reads of addrs 0-3 together after reset -> grants in order 0,1,2,3; each LSU receives its own data 0,1,2,3 in its own slice; other slices unchanged.
- Fairness: rr_ptr=1; LSU0 re-requests immediately after completing; LSU2 pending -> LSU2 is granted before LSU0 again.
- Read+write same LSU with memory stalling 5 cycles: LSU2 asserts both -> read completes first with valid held 5 cycles; write follows on its next turn; mem read and write valids never overlap.
- Reset mid-op: reset_n=0 during WRITE_WAIT -> all outputs 0 immediately (async); after release the state is IDLE, rr_ptr=0, and no stale ready is issued.
